// File: rtl/lsu_mem_stage_if.sv
// Data-memory port between the load/store unit and memory.
// Signal names are from the LSU side. The master is the LSU and the slave is memory.
//   mem_req_o    request, held until granted
//   mem_gnt_i    request accepted by memory
//   mem_we_o     1 = write
//   mem_addr_o   word-aligned byte address
//   mem_be_o     byte enables
//   mem_wdata_o  lane-replicated store data
//   mem_rvalid_i read data valid / write acknowledge
//   mem_rdata_i  read word
interface lsu_mem_stage_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned BE_W = DATA_W / 8;

  logic              mem_req_o;
  logic              mem_gnt_i;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [BE_W-1:0]   mem_be_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_rvalid_i;
  logic [DATA_W-1:0] mem_rdata_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );
endinterface

// File: rtl/lsu_mem_stage.sv
// Load/store unit sitting after the ALU. It runs one aligned access on a req/gnt/rvalid
// memory port. Misaligned accesses and illegal funct3 values are trapped locally and
// never reach memory.
// Ports:
//   clk_i, rst_ni     clock and asynchronous active-low reset
//   lsu_valid_i       access request from execute; accepted when valid & ready
//   lsu_we_i          1 = store, 0 = load
//   lsu_funct3_i      RV32I load/store funct3
//   lsu_addr_i        byte address
//   lsu_wdata_i       store data
//   lsu_ready_o       high while idle
//   lsu_done_o        one-cycle completion pulse
//   lsu_err_o         pulses together with done on a trapped access
//   lsu_rdata_o       extended load data; held unless a load completes
//   mem               data-memory port (master side)
module lsu_mem_stage #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              lsu_valid_i,
  input  logic              lsu_we_i,
  input  logic [2:0]        lsu_funct3_i,
  input  logic [ADDR_W-1:0] lsu_addr_i,
  input  logic [DATA_W-1:0] lsu_wdata_i,
  output logic              lsu_ready_o,
  output logic              lsu_done_o,
  output logic              lsu_err_o,
  output logic [DATA_W-1:0] lsu_rdata_o,
  lsu_mem_stage_if.master   mem
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RSP, S_ERR} state_e;

  state_e      r_state;
  logic [2:0]  r_funct3;
  logic [1:0]  r_addr_lo;

  logic              w_legal;
  logic              w_misal;
  logic [3:0]        w_be;
  logic [DATA_W-1:0] w_wdata;
  logic [7:0]        w_rd_b;
  logic [15:0]       w_rd_h;
  logic [DATA_W-1:0] w_ld_data;

  // Legality of funct3. Unsigned loads have no store counterpart.
  always_comb begin
    w_legal = 1'b0;
    case (lsu_funct3_i)
      3'b000, 3'b001, 3'b010: w_legal = 1'b1;
      3'b100, 3'b101:         w_legal = !lsu_we_i;
      default:                w_legal = 1'b0;
    endcase
  end

  // Natural alignment. funct3[1:0] encodes the access size.
  always_comb begin
    w_misal = 1'b0;
    case (lsu_funct3_i[1:0])
      2'b01:   w_misal = lsu_addr_i[0];
      2'b10:   w_misal = |lsu_addr_i[1:0];
      default: w_misal = 1'b0;
    endcase
  end

  // Byte enables and lane-replicated store data for the incoming request.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = '0;
    case (lsu_funct3_i[1:0])
      2'b00: begin
        w_be    = 4'b0001 << lsu_addr_i[1:0];
        w_wdata = DATA_W'({4{lsu_wdata_i[7:0]}});
      end
      2'b01: begin
        w_be    = 4'b0011 << {lsu_addr_i[1], 1'b0};
        w_wdata = DATA_W'({2{lsu_wdata_i[15:0]}});
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = lsu_wdata_i;
      end
    endcase
    if (!lsu_we_i) w_wdata = '0;
  end

  // Select the lane for the load, then sign- or zero-extend it.
  assign w_rd_b = 8'(mem.mem_rdata_i >> {r_addr_lo, 3'b000});
  assign w_rd_h = 16'(mem.mem_rdata_i >> {r_addr_lo[1], 4'b0000});

  always_comb begin
    w_ld_data = mem.mem_rdata_i;
    case (r_funct3)
      3'b000:  w_ld_data = DATA_W'({{24{w_rd_b[7]}}, w_rd_b});
      3'b001:  w_ld_data = DATA_W'({{16{w_rd_h[15]}}, w_rd_h});
      3'b100:  w_ld_data = DATA_W'({24'b0, w_rd_b});
      3'b101:  w_ld_data = DATA_W'({16'b0, w_rd_h});
      default: w_ld_data = mem.mem_rdata_i;
    endcase
  end

  // Access sequencer. All outputs are registered.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state         <= S_IDLE;
      r_funct3        <= '0;
      r_addr_lo       <= '0;
      lsu_ready_o     <= 1'b1;
      lsu_done_o      <= 1'b0;
      lsu_err_o       <= 1'b0;
      lsu_rdata_o     <= '0;
      mem.mem_req_o   <= 1'b0;
      mem.mem_we_o    <= 1'b0;
      mem.mem_addr_o  <= '0;
      mem.mem_be_o    <= '0;
      mem.mem_wdata_o <= '0;
    end else begin
      lsu_done_o <= 1'b0;
      lsu_err_o  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (lsu_valid_i) begin
            r_funct3    <= lsu_funct3_i;
            r_addr_lo   <= lsu_addr_i[1:0];
            lsu_ready_o <= 1'b0;
            if (!w_legal || w_misal) begin
              // A trapped access reports immediately and leaves the memory port untouched.
              r_state    <= S_ERR;
              lsu_done_o <= 1'b1;
              lsu_err_o  <= 1'b1;
            end else begin
              r_state         <= S_REQ;
              mem.mem_req_o   <= 1'b1;
              mem.mem_we_o    <= lsu_we_i;
              mem.mem_addr_o  <= {lsu_addr_i[ADDR_W-1:2], 2'b00};
              mem.mem_be_o    <= w_be;
              mem.mem_wdata_o <= w_wdata;
            end
          end
        end
        S_REQ: begin
          if (mem.mem_gnt_i) begin
            mem.mem_req_o <= 1'b0;
            r_state       <= S_RSP;
          end
        end
        S_RSP: begin
          if (mem.mem_rvalid_i) begin
            r_state     <= S_IDLE;
            lsu_done_o  <= 1'b1;
            lsu_ready_o <= 1'b1;
            if (!mem.mem_we_o) lsu_rdata_o <= w_ld_data;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          lsu_ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Scoreboard bench for lsu_mem_stage. The bench drives requests and a memory responder
// with configurable grant and response delays. Expected completions and memory requests
// are queued when an access is issued, then checked when the DUT produces them.
module tb_lsu_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lsu_valid_i, lsu_we_i;
  logic [2:0]  lsu_funct3_i;
  logic [31:0] lsu_addr_i, lsu_wdata_i;
  logic        lsu_ready_o, lsu_done_o, lsu_err_o;
  logic [31:0] lsu_rdata_o;

  always #5 clk = ~clk;

  lsu_mem_stage_if #(.ADDR_W(32), .DATA_W(32)) mem_if ();

  lsu_mem_stage #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .lsu_valid_i (lsu_valid_i),
    .lsu_we_i    (lsu_we_i),
    .lsu_funct3_i(lsu_funct3_i),
    .lsu_addr_i  (lsu_addr_i),
    .lsu_wdata_i (lsu_wdata_i),
    .lsu_ready_o (lsu_ready_o),
    .lsu_done_o  (lsu_done_o),
    .lsu_err_o   (lsu_err_o),
    .lsu_rdata_o (lsu_rdata_o),
    .mem         (mem_if)
  );

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } done_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          cyc;
    int          gw;
    int          rw;
    logic [31:0] rd;
  } req_t;

  done_t       sb[$];
  req_t        rq[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [31:0] model_rdata = '0;

  int          gnt_cnt = 0;
  int          rsp_cnt = 0;
  bit          rsp_pend = 1'b0;
  int          rsp_wait = 0;
  logic [31:0] rsp_data = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc = cyc + 1;

  // Memory responder. Each request is checked against its queued expectation on every
  // cycle it is pending, so the bus must hold steady while it waits for a grant.
  always @(negedge clk) begin
    req_t r;
    mem_if.mem_gnt_i    = 1'b0;
    mem_if.mem_rvalid_i = 1'b0;
    mem_if.mem_rdata_i  = 32'($urandom);
    if (!rst_n) gnt_cnt = 0;
    if (rsp_pend) begin
      if (rsp_cnt == rsp_wait) begin
        mem_if.mem_rvalid_i = 1'b1;
        mem_if.mem_rdata_i  = rsp_data;
        rsp_pend = 1'b0;
      end else begin
        rsp_cnt++;
      end
    end else if (rst_n && mem_if.mem_req_o) begin
      if (rq.size() == 0) begin
        chk("unexpected_req", 32'd1, 32'd0);
        mem_if.mem_gnt_i = 1'b1;
        rsp_pend = 1'b1; rsp_cnt = 0; rsp_wait = 0; rsp_data = '0;
      end else begin
        r = rq[0];
        if (gnt_cnt == 0) chk("req_cyc", 32'(cyc), 32'(r.cyc));
        chk("mem_we",    32'(mem_if.mem_we_o), 32'(r.we));
        chk("mem_addr",  mem_if.mem_addr_o,    r.addr);
        chk("mem_be",    32'(mem_if.mem_be_o), 32'(r.be));
        chk("mem_wdata", mem_if.mem_wdata_o,   r.wdata);
        if (gnt_cnt == r.gw) begin
          mem_if.mem_gnt_i = 1'b1;
          rsp_pend = 1'b1; rsp_cnt = 0; rsp_wait = r.rw; rsp_data = r.rd;
          gnt_cnt = 0;
          void'(rq.pop_front());
        end else begin
          gnt_cnt++;
        end
      end
    end
  end

  // Completion monitor.
  always @(negedge clk) begin
    done_t d;
    if (rst_n && lsu_done_o) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        d = sb.pop_front();
        chk("done_cyc", 32'(cyc), 32'(d.cyc));
        chk("done_err", 32'(lsu_err_o), 32'(d.err));
        chk("rdata", lsu_rdata_o, d.rdata);
      end
    end
    if (rst_n && lsu_err_o && !lsu_done_o) chk("err_without_done", 32'd1, 32'd0);
  end

  // Issue one access. Expected memory request and completion are queued when accepted.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] rd, input int gw,
                       input int rw, input logic err, input logic [3:0] be,
                       input logic [31:0] ewd, input logic [31:0] erd, output int acc);
    int    n;
    int    e;
    done_t d;
    req_t  r;
    acc = -1;
    @(negedge clk);
    lsu_valid_i = 1'b1; lsu_we_i = we; lsu_funct3_i = f3;
    lsu_addr_i = addr; lsu_wdata_i = wd;
    n = 0;
    while (!lsu_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!lsu_ready_o) begin
      chk("ready_timeout", 32'd0, 32'd1);
      lsu_valid_i = 1'b0;
      return;
    end
    e = cyc + 1;
    acc = e;
    d.err = err;
    d.cyc = err ? e : e + 2 + gw + rw;
    if (err || we) begin
      d.rdata = model_rdata;
    end else begin
      d.rdata = erd;
      model_rdata = erd;
    end
    sb.push_back(d);
    if (!err) begin
      r = '{we, addr & 32'hFFFF_FFFC, be, ewd, e, gw, rw, rd};
      rq.push_back(r);
    end
    @(posedge clk);
    #1;
    lsu_valid_i = 1'b0;
    lsu_we_i = 1'($urandom); lsu_funct3_i = 3'($urandom);
    lsu_addr_i = 32'($urandom); lsu_wdata_i = 32'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || rq.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(sb.size() + rq.size()), 32'd0);
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_ready"}, 32'(lsu_ready_o),        32'd1);
    chk({pfx, "_done"},  32'(lsu_done_o),         32'd0);
    chk({pfx, "_err"},   32'(lsu_err_o),          32'd0);
    chk({pfx, "_rdata"}, lsu_rdata_o,             32'd0);
    chk({pfx, "_req"},   32'(mem_if.mem_req_o),   32'd0);
    chk({pfx, "_we"},    32'(mem_if.mem_we_o),    32'd0);
    chk({pfx, "_addr"},  mem_if.mem_addr_o,       32'd0);
    chk({pfx, "_be"},    32'(mem_if.mem_be_o),    32'd0);
    chk({pfx, "_wdata"}, mem_if.mem_wdata_o,      32'd0);
  endtask

  initial begin
    int a0, a1;
    lsu_valid_i = 1'b0; lsu_we_i = 1'b0; lsu_funct3_i = '0;
    lsu_addr_i = '0; lsu_wdata_i = '0;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(lsu_ready_o), 32'd1);

    // we, f3, addr, wdata, mem rdata, gnt wait, rsp wait, err, be, exp wdata, exp rdata
    issue(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 1'b0, 4'b1111, 32'h0, 32'hDEADBEEF, a0);
    issue(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF0000, 0, 0, 1'b0, 4'b1000, 32'h0, 32'hFFFFFF80, a0);
    issue(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF0000, 0, 0, 1'b0, 4'b1000, 32'h0, 32'h00000080, a0);
    issue(1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 3, 0, 1'b0, 4'b1100, 32'hABCDABCD, 32'h0, a0);
    drain();

    // Trapped accesses: misaligned word, illegal load funct3, illegal store funct3.
    issue(1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 0, 0, 1'b1, 4'b0000, 32'h0, 32'h0, a0);
    issue(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 0, 1'b1, 4'b0000, 32'h0, 32'h0, a0);
    issue(1'b1, 3'b100, 32'h000, 32'h0, 32'h0, 0, 0, 1'b1, 4'b0000, 32'h0, 32'h0, a0);
    issue(1'b0, 3'b001, 32'h001, 32'h0, 32'h0, 0, 0, 1'b1, 4'b0000, 32'h0, 32'h0, a0);
    drain();

    // Back-to-back: the second access is accepted in the done cycle of the first.
    issue(1'b0, 3'b010, 32'h010, 32'h0, 32'h11223344, 0, 0, 1'b0, 4'b1111, 32'h0, 32'h11223344, a0);
    issue(1'b0, 3'b101, 32'h002, 32'h0, 32'hF00D0000, 0, 0, 1'b0, 4'b1100, 32'h0, 32'h0000F00D, a1);
    chk("b2b_gap", 32'(a1 - a0), 32'd3);
    drain();

    // Remaining lanes and response delays.
    issue(1'b1, 3'b000, 32'h001, 32'h000000A5, 32'h0, 0, 1, 1'b0, 4'b0010, 32'hA5A5A5A5, 32'h0, a0);
    issue(1'b0, 3'b001, 32'h002, 32'h0, 32'h80011234, 1, 2, 1'b0, 4'b1100, 32'h0, 32'hFFFF8001, a0);
    issue(1'b1, 3'b010, 32'h00C, 32'hCAFEF00D, 32'h0, 1, 1, 1'b0, 4'b1111, 32'hCAFEF00D, 32'h0, a0);
    issue(1'b0, 3'b000, 32'h001, 32'h0, 32'h00007F00, 0, 0, 1'b0, 4'b0010, 32'h0, 32'h0000007F, a0);
    drain();

    // Reset while waiting for the response, then a stray rvalid.
    issue(1'b0, 3'b010, 32'h040, 32'h0, 32'h00000077, 0, 2, 1'b0, 4'b1111, 32'h0, 32'h00000077, a0);
    @(negedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    sb.delete();
    model_rdata = '0;
    #1;
    chk_reset_vals("midrst");
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("stray_done",  32'(lsu_done_o),  32'd0);
    chk("stray_ready", 32'(lsu_ready_o), 32'd1);
    chk("stray_rdata", lsu_rdata_o,      32'd0);

    // Recovery after reset.
    issue(1'b0, 3'b010, 32'h004, 32'h0, 32'h5A5A0001, 0, 0, 1'b0, 4'b1111, 32'h0, 32'h5A5A0001, a0);
    drain();

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
